shiftrows_mixcolumns_addkey_block: RTL and testbench
====================================================

// Module: shiftrows_mixcolumns_addkey_block
// PURPOSE
// AES round back-end stage directly downstream of the 16-byte S-Box (SubBytes) block.
// Applies ShiftRows, then MixColumns (bypassed on the final round), then AddRoundKey.
// Two-stage registered pipeline with valid/ready backpressure; round tag and last flag travel with the data.
// Output feeds the next round's SubBytes input, or the ciphertext register after the final round.
// PARAMETERS
// NB_BYTE    8   bits per byte; any other value is a bad configuration (elaboration error)
// N_BYTES    16  bytes per state; any other value is a bad configuration
// NB_ROUND   4   width of the round tag carried alongside the state
// PORTS
// i_clock        in   1        single clock, all flops on the rising edge
// i_reset        in   1        asynchronous, active-high reset
// i_state        in   128      SubBytes output; byte k = i_state[k*8+:8], k = 4*col + row
// i_round_key    in   128      round key, same byte order, sampled with i_state
// i_round        in   NB_ROUND round index tag, sampled with i_state
// i_last_round   in   1        1 = final round: skip MixColumns
// i_valid        in   1        input beat valid
// o_ready        out  1        stage can accept a beat this cycle
// o_state        out  128      round result
// o_round        out  NB_ROUND tag of o_state
// o_last_round   out  1        last flag of o_state
// o_valid        out  1        output beat valid
// i_ready        in   1        downstream accepts the output beat
// BEHAVIOUR
// - Reset (async assert, sync deassert handled outside): s1_valid=0, o_valid=0; o_state, o_round, o_last_round = 0; o_ready=1 after reset.
// - ShiftRows: sr[r+4c] = in[r+4*((c+r)%4)], r,c in 0..3.
// - MixColumns per column, GF(2^8) mod 0x11B: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0);
//   matrix rows {2,3,1,1}, {1,2,3,1}, {1,1,2,3}, {3,1,1,2}.
// - Stage 1 (input accept): registers mc = last ? sr : MixColumns(sr), plus key, round, last.
// - Stage 2 (output): o_state <= s1_mc ^ s1_key; o_round and o_last_round are copied.
// - Latency: exactly 2 cycles from accepted input to o_valid when there are no stalls.
// - Handshake:
//   - beat accepted when i_valid & o_ready;
//   - output consumed when o_valid & i_ready.
//   - adv2 = ~o_valid | i_ready; adv1 = ~s1_valid | adv2; o_ready = adv1 (combinational, no input-to-ready path).
//   - Stalled registers hold their contents; o_state is stable while o_valid & ~i_ready.
// - Full pipe (s1_valid & o_valid) with i_ready=0: o_ready=0; any i_valid beat is not taken and the upstream must hold it.
// - Simultaneous accept and consume: both stages advance in the same cycle; throughput is 1 beat per cycle; no bubble inserted.
// - Empty pipe: o_valid=0; the o_state value is don't-care but is not updated by garbage (registers load only on advance with a valid beat).
// - Reset mid-operation: all in-flight beats are dropped; valid flags clear immediately (async).
// - No internal round counting: rounds are sequenced by the controller via i_round and i_last_round.
// TESTING
// - FIPS-197 round 1: i_state bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30,
//   key = a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05, last=0
//   -> o_state = a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49, 2 cycles later.
// - Same state and key with last=1 -> o_state = ShiftRows ^ key
//   = 74 45 a3 27 68 e0 7e 1f 9b e2 28 c8 34 4b ee e0.
// - MixColumns column check: column db 13 53 45, zero key -> 8e 4d a1 bc; column c6 c6 c6 c6 -> unchanged.
// - Backpressure: stream 4 beats (round tags 1..4), hold i_ready=0 for 3 cycles.
//   -> o_ready=0 once both stages are full; o_state and o_round stable; all 4 beats delivered in order with no loss or duplication.
// - Full throughput: i_valid=i_ready=1 for 10 beats -> 10 outputs on consecutive cycles, starting at cycle 2.
// - Assert i_reset with 2 beats in flight -> o_valid=0 and o_state=0 immediately; the first beat after release emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/shiftrows_mixcolumns_addkey_block_if.sv
// Beat-level bus of the AES round back-end: upstream state/key/tag beat in,
// round result beat out, each side with its own valid/ready pair.
interface shiftrows_mixcolumns_addkey_block_if #(
    parameter int NB_BYTE  = 8,
    parameter int N_BYTES  = 16,
    parameter int NB_ROUND = 4
);
    logic [NB_BYTE*N_BYTES-1:0] in_state;
    logic [NB_BYTE*N_BYTES-1:0] in_round_key;
    logic [NB_ROUND-1:0]        in_round;
    logic                       in_last_round;
    logic                       in_valid;
    logic                       in_ready;

    logic [NB_BYTE*N_BYTES-1:0] out_state;
    logic [NB_ROUND-1:0]        out_round;
    logic                       out_last_round;
    logic                       out_valid;
    logic                       out_ready;

    modport slave (
        input  in_state,
        input  in_round_key,
        input  in_round,
        input  in_last_round,
        input  in_valid,
        output in_ready,
        output out_state,
        output out_round,
        output out_last_round,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_state,
        output in_round_key,
        output in_round,
        output in_last_round,
        output in_valid,
        input  in_ready,
        input  out_state,
        input  out_round,
        input  out_last_round,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/shiftrows_mixcolumns_addkey_block.sv
// AES round back-end: ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey,
// as a two-stage valid/ready pipeline carrying the round tag and last flag with the data.
module shiftrows_mixcolumns_addkey_block #(
    parameter int NB_BYTE  = 8,
    parameter int N_BYTES  = 16,
    parameter int NB_ROUND = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    shiftrows_mixcolumns_addkey_block_if.slave    bus
);

    localparam int NB_STATE = NB_BYTE * N_BYTES;
    localparam int N_COLS   = N_BYTES / 4;

    generate
        if (NB_BYTE != 8) begin : g_bad_nb_byte
            $error("shiftrows_mixcolumns_addkey_block: NB_BYTE must be 8");
        end
        if (N_BYTES != 16) begin : g_bad_n_bytes
            $error("shiftrows_mixcolumns_addkey_block: N_BYTES must be 16");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One state column: rows {2,3,1,1} {1,2,3,1} {1,1,2,3} {3,1,1,2}; byte r of col sits at col[r*8+:8].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [31:0] res;
        b0 = col[7:0];
        b1 = col[15:8];
        b2 = col[23:16];
        b3 = col[31:24];
        res[7:0]   = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        res[15:8]  = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
        res[23:16] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
        res[31:24] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        return res;
    endfunction

    function automatic logic [NB_STATE-1:0] mix_columns(input logic [NB_STATE-1:0] st);
        logic [NB_STATE-1:0] res;
        res = '0;
        for (int c = 0; c < N_COLS; c++) begin
            res[c*32 +: 32] = mix_column(st[c*32 +: 32]);
        end
        return res;
    endfunction

    // Row r rotates left by r columns: out[r+4c] = in[r+4*((c+r)%4)].
    function automatic logic [NB_STATE-1:0] shift_rows(input logic [NB_STATE-1:0] st);
        logic [NB_STATE-1:0] res;
        res = '0;
        for (int c = 0; c < N_COLS; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[(r + 4*c)*NB_BYTE +: NB_BYTE] = st[(r + 4*((c + r) % 4))*NB_BYTE +: NB_BYTE];
            end
        end
        return res;
    endfunction

    logic                s1_valid_q;
    logic                s1_valid_d;
    logic [NB_STATE-1:0] s1_mc_q;
    logic [NB_STATE-1:0] s1_mc_d;
    logic [NB_STATE-1:0] s1_key_q;
    logic [NB_STATE-1:0] s1_key_d;
    logic [NB_ROUND-1:0] s1_round_q;
    logic [NB_ROUND-1:0] s1_round_d;
    logic                s1_last_q;
    logic                s1_last_d;

    logic                o_valid_q;
    logic                o_valid_d;
    logic [NB_STATE-1:0] o_state_q;
    logic [NB_STATE-1:0] o_state_d;
    logic [NB_ROUND-1:0] o_round_q;
    logic [NB_ROUND-1:0] o_round_d;
    logic                o_last_q;
    logic                o_last_d;

    logic [NB_STATE-1:0] sr_s;
    logic [NB_STATE-1:0] mc_s;
    logic                adv1_s;
    logic                adv2_s;

    // Round datapath on the incoming beat; the final round bypasses MixColumns.
    always_comb begin
        sr_s = shift_rows(bus.in_state);
        if (bus.in_last_round) begin
            mc_s = sr_s;
        end else begin
            mc_s = mix_columns(sr_s);
        end
    end

    // Stage advance: ready depends only on downstream ready and stage occupancy, never on in_valid.
    always_comb begin
        adv2_s = ~o_valid_q | bus.out_ready;
        adv1_s = ~s1_valid_q | adv2_s;
    end

    // Next-state for both stages; data registers load only when a valid beat advances into them.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mc_d    = s1_mc_q;
        s1_key_d   = s1_key_q;
        s1_round_d = s1_round_q;
        s1_last_d  = s1_last_q;
        o_valid_d  = o_valid_q;
        o_state_d  = o_state_q;
        o_round_d  = o_round_q;
        o_last_d   = o_last_q;

        if (adv1_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_mc_d    = mc_s;
                s1_key_d   = bus.in_round_key;
                s1_round_d = bus.in_round;
                s1_last_d  = bus.in_last_round;
            end else begin
                s1_mc_d    = s1_mc_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (adv2_s) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_state_d = s1_mc_q ^ s1_key_q;
                o_round_d = s1_round_q;
                o_last_d  = s1_last_q;
            end else begin
                o_state_d = o_state_q;
            end
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Pipeline registers; reset drops every in-flight beat at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_mc_q    <= '0;
            s1_key_q   <= '0;
            s1_round_q <= '0;
            s1_last_q  <= 1'b0;
            o_valid_q  <= 1'b0;
            o_state_q  <= '0;
            o_round_q  <= '0;
            o_last_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mc_q    <= s1_mc_d;
            s1_key_q   <= s1_key_d;
            s1_round_q <= s1_round_d;
            s1_last_q  <= s1_last_d;
            o_valid_q  <= o_valid_d;
            o_state_q  <= o_state_d;
            o_round_q  <= o_round_d;
            o_last_q   <= o_last_d;
        end
    end

    assign bus.in_ready       = adv1_s;
    assign bus.out_valid      = o_valid_q;
    assign bus.out_state      = o_state_q;
    assign bus.out_round      = o_round_q;
    assign bus.out_last_round = o_last_q;

endmodule

// File: tb/tb_shiftrows_mixcolumns_addkey_block.sv
// Scoreboard bench for the AES round back-end: a byte-array reference model fills
// an expected queue on each accepted beat; a monitor pops and compares each output beat.
module tb_shiftrows_mixcolumns_addkey_block;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   mode;
    int   last_acc_cyc;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
        int           acc_cyc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];

    shiftrows_mixcolumns_addkey_block_if bus ();

    shiftrows_mixcolumns_addkey_block dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream ready: 0 = stall, 1 = always ready, otherwise random.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1B;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key, input logic last);
        logic [7:0]   a[16];
        logic [7:0]   s[16];
        logic [7:0]   m[16];
        logic [127:0] r;
        int           base[4] = '{2, 3, 1, 1};
        for (int k = 0; k < 16; k++) a[k] = st[k*8 +: 8];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                s[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                m[rr + 4*c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    m[rr + 4*c] = m[rr + 4*c] ^ gmul(8'(base[(j - rr + 4) % 4]), s[j + 4*c]);
            end
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = (last ? s[k] : m[k]) ^ key[k*8 +: 8];
        return r;
    endfunction

    // Byte list written left-to-right as bytes 0..15 -> packed state with byte k at [k*8+:8].
    function automatic logic [127:0] lst(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = v[(15 - k)*8 +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare every consumed output beat against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h expected no beat", bus.out_state);
                end else begin
                    e = sb.pop_front();
                    check("out_state", bus.out_state, e.st);
                    check("out_round", {124'b0, bus.out_round}, {124'b0, e.rnd});
                    check("out_last", {127'b0, bus.out_last_round}, {127'b0, e.last});
                    if (e.chk_lat) check("latency", 128'(cyc - e.acc_cyc), 128'd2);
                end
            end
        end
    end

    task automatic send(input logic [127:0] st, input logic [127:0] key, input logic [3:0] rnd,
                        input logic last, input bit use_exp, input logic [127:0] exp_st, input bit lat);
        exp_t e;
        int   waited;
        bit   done;
        waited = 0;
        done   = 1'b0;
        bus.in_state      = st;
        bus.in_round_key  = key;
        bus.in_round      = rnd;
        bus.in_last_round = last;
        bus.in_valid      = 1'b1;
        e.st      = use_exp ? exp_st : ref_round(st, key, last);
        e.rnd     = rnd;
        e.last    = last;
        e.chk_lat = lat;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc_cyc    = cyc;
                last_acc_cyc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    n_checks++;
                    $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] fips_in;
        logic [127:0] fips_key;
        logic [127:0] st_a;
        logic [127:0] st_b;
        int           first_acc;

        fips_in  = lst(128'hd42711aee0bf98f1b8b45de51e415230);
        fips_key = lst(128'ha0fafe1788542cb123a339392a6c7605);
        n_checks = 0;
        n_pass   = 0;
        mode     = 1;
        last_acc_cyc = 0;
        rst = 1'b1;
        bus.in_state      = '0;
        bus.in_round_key  = '0;
        bus.in_round      = '0;
        bus.in_last_round = 1'b0;
        bus.in_valid      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("rst_out_state", bus.out_state, 128'd0);
        check("rst_out_round", {124'b0, bus.out_round}, 128'd0);
        check("rst_out_last", {127'b0, bus.out_last_round}, 128'd0);
        check("rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Known-answer beats, back to back with downstream always ready.
        send(fips_in, fips_key, 4'd1, 1'b0, 1'b1, lst(128'ha49c7ff2689f352b6b5bea43026a5049), 1'b1);
        send(fips_in, fips_key, 4'd10, 1'b1, 1'b1, lst(128'h7445a32768e07e1f9be228c8344beee0), 1'b1);
        send(lst(128'hdb135345db135345db135345db135345), 128'd0, 4'd2, 1'b0, 1'b1,
             lst(128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc), 1'b1);
        send(lst(128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6), 128'd0, 4'd3, 1'b0, 1'b1,
             lst(128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6), 1'b1);
        drain();

        // Full throughput: ten consecutive accepts.
        first_acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(rnd128(), rnd128(), 4'(i), 1'($urandom_range(0, 1)), 1'b0, 128'd0, 1'b1);
            if (i == 0) first_acc = last_acc_cyc;
        end
        check("throughput_accepts", 128'(last_acc_cyc - first_acc), 128'd9);
        drain();

        // Backpressure: fill both stages, then hold a third beat against a stalled sink.
        mode = 0;
        @(posedge clk);
        #3;
        st_a = rnd128();
        st_b = rnd128();
        send(rnd128(), rnd128(), 4'd1, 1'b0, 1'b0, 128'd0, 1'b0);
        send(rnd128(), rnd128(), 4'd2, 1'b1, 1'b0, 128'd0, 1'b0);
        bus.in_state      = st_a;
        bus.in_round_key  = st_b;
        bus.in_round      = 4'd3;
        bus.in_last_round = 1'b0;
        bus.in_valid      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {127'b0, bus.in_ready}, 128'd0);
            check("stall_out_valid", {127'b0, bus.out_valid}, 128'd1);
            check("stall_out_round", {124'b0, bus.out_round}, 128'd1);
            check("stall_out_state", bus.out_state, (sb.size() > 0) ? sb[0].st : 128'd0);
            @(posedge clk);
            #1;
        end
        mode = 1;
        send(st_a, st_b, 4'd3, 1'b0, 1'b0, 128'd0, 1'b0);
        send(rnd128(), rnd128(), 4'd4, 1'b0, 1'b0, 128'd0, 1'b0);
        drain();

        // Reset with two beats in flight.
        mode = 0;
        @(posedge clk);
        #3;
        send(rnd128(), rnd128(), 4'd5, 1'b0, 1'b0, 128'd0, 1'b0);
        send(rnd128(), rnd128(), 4'd6, 1'b0, 1'b0, 128'd0, 1'b0);
        check("pre_rst_out_valid", {127'b0, bus.out_valid}, 128'd1);
        sb.delete();
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("mid_rst_out_state", bus.out_state, 128'd0);
        check("mid_rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mode = 1;
        @(posedge clk);
        #1;
        send(rnd128(), rnd128(), 4'd7, 1'b1, 1'b0, 128'd0, 1'b1);
        drain();

        // Random traffic with random downstream stalls.
        mode = 2;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(rnd128(), rnd128(), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0, 128'd0, 1'b0);
        end
        mode = 1;
        drain();

        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
